// File: rtl/phys_reg_free_list_pkg.sv
// Shared sizing and tag/pointer types for the physical register free list.
package phys_reg_free_list_pkg;
  localparam int PHY_REGS  = 64;
  localparam int ARCH_REGS = 32;
  localparam int PHY_WIDTH = $clog2(PHY_REGS);

  typedef logic [PHY_WIDTH-1:0] preg_t;
  // Extra MSB is the wrap bit so full and empty are distinguishable.
  typedef logic [PHY_WIDTH:0]   fl_ptr_t;
endpackage

// File: rtl/phys_reg_free_list_if.sv
// Rename/ROB-facing signal bundle of the free list; slave is the list itself.
interface phys_reg_free_list_if;
  import phys_reg_free_list_pkg::*;

  logic    alloc_req;
  logic    alloc_valid;
  preg_t   alloc_preg;
  logic    commit_en;
  logic    free_en;
  preg_t   free_preg;
  logic    flush;
  fl_ptr_t free_count;
  logic    error;

  modport master (
    output alloc_req, commit_en, free_en, free_preg, flush,
    input  alloc_valid, alloc_preg, free_count, error
  );

  modport slave (
    input  alloc_req, commit_en, free_en, free_preg, flush,
    output alloc_valid, alloc_preg, free_count, error
  );
endinterface

// File: rtl/phys_reg_free_list.sv
// Circular free list of physical tags with commit-pointer rewind on flush.
// Optional FREELIST_DOUBLE_FREE_CHECK_EN adds an in-list bitmap that rejects double frees.
module phys_reg_free_list
  import phys_reg_free_list_pkg::*;
(
  input logic                 clk,
  input logic                 rst,
  phys_reg_free_list_if.slave fl
);

  preg_t   mem [PHY_REGS];
  fl_ptr_t head, tail, commit_head, free_count_q;
  logic    error_q;

  fl_ptr_t count, head_nxt, tail_nxt, commit_head_nxt;
  logic    empty, full, grant, dup_free, free_ok, free_err, commit_err;

  assign count = tail - head;
  assign empty = (count == '0);
  assign full  = (count == fl_ptr_t'(PHY_REGS));

  assign fl.alloc_valid = !empty && !fl.flush;
  assign fl.alloc_preg  = mem[head[PHY_WIDTH-1:0]];
  assign fl.free_count  = free_count_q;
  assign fl.error       = error_q;

  assign grant      = fl.alloc_req && fl.alloc_valid;
  assign free_ok    = fl.free_en && !full && !dup_free;
  assign free_err   = fl.free_en && (full || dup_free);
  // Committing with nothing allocated is a protocol error and is not applied.
  assign commit_err = fl.commit_en && (commit_head == head);

  assign commit_head_nxt = commit_head + fl_ptr_t'(fl.commit_en && !commit_err);
  assign head_nxt        = fl.flush ? commit_head_nxt : head + fl_ptr_t'(grant);
  assign tail_nxt        = tail + fl_ptr_t'(free_ok);

`ifdef FREELIST_DOUBLE_FREE_CHECK_EN
  logic [PHY_REGS-1:0] in_list, in_list_nxt;
  fl_ptr_t             spec_cnt;
  preg_t               off;

  assign dup_free = in_list[fl.free_preg] || (fl.free_preg == '0);
  assign spec_cnt = head - commit_head_nxt;

  // On flush every tag between the committed head and the live head goes back in the list.
  always_comb begin
    in_list_nxt = in_list;
    off         = '0;
    if (grant)   in_list_nxt[fl.alloc_preg] = 1'b0;
    if (free_ok) in_list_nxt[fl.free_preg]  = 1'b1;
    if (fl.flush) begin
      for (int i = 0; i < PHY_REGS; i++) begin
        off = preg_t'(i) - commit_head_nxt[PHY_WIDTH-1:0];
        if ({1'b0, off} < spec_cnt) in_list_nxt[mem[i]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) in_list <= {{(PHY_REGS-ARCH_REGS){1'b1}}, {ARCH_REGS{1'b0}}};
    else     in_list <= in_list_nxt;
  end
`else
  assign dup_free = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PHY_REGS; i++)
        mem[i] <= (i < PHY_REGS-ARCH_REGS) ? preg_t'(ARCH_REGS+i) : '0;
      head         <= '0;
      commit_head  <= '0;
      tail         <= fl_ptr_t'(PHY_REGS-ARCH_REGS);
      free_count_q <= fl_ptr_t'(PHY_REGS-ARCH_REGS);
      error_q      <= 1'b0;
    end else begin
      if (free_ok) mem[tail[PHY_WIDTH-1:0]] <= fl.free_preg;
      head         <= head_nxt;
      commit_head  <= commit_head_nxt;
      tail         <= tail_nxt;
      free_count_q <= tail_nxt - head_nxt;
      if (free_err || commit_err) error_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Scoreboard bench for phys_reg_free_list: a queue-based model of free and in-flight tags
// predicts each cycle's outputs; a negedge monitor compares them against the DUT.
module tb_phys_reg_free_list;
  import phys_reg_free_list_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  phys_reg_free_list_if fl();
  phys_reg_free_list dut (.clk(clk), .rst(rst), .fl(fl));

  typedef struct {
    string name;
    bit    valid;
    int    preg;
    int    cnt;
    bit    err;
  } exp_t;

  exp_t exp_q[$];
  int   fl_q[$];   // tags in the list, head first
  int   sp_q[$];   // allocated, not yet committed, oldest first
  bit   m_err;
  int   tests_run = 0;
  int   tests_failed = 0;

  task automatic chk(input string name, input string field, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s.%s: got %0d, expected %0d", name, field, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk(e.name, "alloc_valid", int'(fl.alloc_valid), int'(e.valid));
        if (e.valid) chk(e.name, "alloc_preg", int'(fl.alloc_preg), e.preg);
        chk(e.name, "free_count", int'(fl.free_count), e.cnt);
        chk(e.name, "error", int'(fl.error), int'(e.err));
      end
    end
  end

  task automatic model_reset();
    fl_q.delete();
    sp_q.delete();
    for (int i = ARCH_REGS; i < PHY_REGS; i++) fl_q.push_back(i);
    m_err = 1'b0;
  endtask

  task automatic do_reset(input bit noisy);
    rst          = 1'b1;
    fl.alloc_req = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
    fl.commit_en = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
    fl.free_en   = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
    fl.free_preg = preg_t'($urandom_range(0, PHY_REGS-1));
    fl.flush     = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic cycle(input string name, input bit req, input bit cen, input bit fen,
                       input int tag, input bit fls);
    exp_t e;
    bit   v, g, full, dup;
    fl.alloc_req = req;
    fl.commit_en = cen;
    fl.free_en   = fen;
    fl.free_preg = preg_t'(tag);
    fl.flush     = fls;

    v       = (fl_q.size() != 0) && !fls;
    e.name  = name;
    e.valid = v;
    e.preg  = v ? fl_q[0] : 0;
    e.cnt   = fl_q.size();
    e.err   = m_err;
    exp_q.push_back(e);

    g    = req && v;
    full = (fl_q.size() == PHY_REGS);
    dup  = 1'b0;
`ifdef FREELIST_DOUBLE_FREE_CHECK_EN
    if (tag == 0) dup = 1'b1;
    foreach (fl_q[k]) if (fl_q[k] == tag) dup = 1'b1;
`endif
    if (cen) begin
      if (sp_q.size() == 0) m_err = 1'b1;
      else void'(sp_q.pop_front());
    end
    if (g) sp_q.push_back(fl_q.pop_front());
    if (fen) begin
      if (full || dup) m_err = 1'b1;
      else fl_q.push_back(tag);
    end
    if (fls) begin
      fl_q = {sp_q, fl_q};
      sp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int prev;
    bit fen;
    rst          = 1'b1;
    fl.alloc_req = 1'b0;
    fl.commit_en = 1'b0;
    fl.free_en   = 1'b0;
    fl.free_preg = '0;
    fl.flush     = 1'b0;

    // Drain the reset image, then one denied request on empty.
    do_reset(1'b0);
    for (int i = 0; i < 32; i++) cycle("t1_alloc", 1'b1, 1'b0, 1'b0, 0, 1'b0);
    cycle("t1_empty", 1'b1, 1'b0, 1'b0, 0, 1'b0);

    // Free into an empty list: no bypass, tag visible next cycle.
    cycle("t2_free_alloc", 1'b1, 1'b0, 1'b1, 7, 1'b0);
    cycle("t2_next", 1'b0, 1'b0, 1'b0, 0, 1'b0);

    // Allocate five, commit two, flush; uncommitted tags return in order.
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) cycle("t3_alloc", 1'b1, 1'b0, 1'b0, 0, 1'b0);
    cycle("t3_commit", 1'b0, 1'b1, 1'b0, 0, 1'b0);
    cycle("t3_commit", 1'b0, 1'b1, 1'b0, 0, 1'b0);
    cycle("t3_flush", 1'b1, 1'b0, 1'b0, 0, 1'b1);
    cycle("t3_after", 1'b1, 1'b0, 1'b0, 0, 1'b0);

    // Steady alloc+free long enough for tail to wrap, then drain to check order.
    do_reset(1'b0);
    prev = 1;
    for (int i = 0; i < 40; i++) begin
      cycle("t4_alloc_free", 1'b1, 1'b0, 1'b1, prev, 1'b0);
      prev = sp_q[sp_q.size()-1];
    end
    for (int i = 0; i < 33; i++) cycle("t4_drain", 1'b1, 1'b0, 1'b0, 0, 1'b0);

    // Fill to full, overflow; then commit with nothing outstanding.
    do_reset(1'b0);
    for (int i = 0; i < 32; i++) cycle("t5_fill", 1'b0, 1'b0, 1'b1, i, 1'b0);
    cycle("t5_overflow", 1'b0, 1'b0, 1'b1, 5, 1'b0);
    cycle("t5_after", 1'b0, 1'b0, 1'b0, 0, 1'b0);
    do_reset(1'b0);
    cycle("t5_bad_commit", 1'b0, 1'b1, 1'b0, 0, 1'b0);
    cycle("t5_after_commit", 1'b0, 1'b0, 1'b0, 0, 1'b0);

    // Free a tag that is already in the list.
    do_reset(1'b0);
    cycle("t6_dup_free", 1'b0, 1'b0, 1'b1, 40, 1'b0);
    cycle("t6_after", 1'b0, 1'b0, 1'b0, 0, 1'b0);

    // Random traffic with a noisy reset partway through.
    do_reset(1'b1);
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset(1'b1);
      fen = ($urandom_range(0, 1) == 1) && ((fl_q.size() + sp_q.size() < PHY_REGS) || (sp_q.size() == 0));
      cycle("rand", $urandom_range(0, 3) != 0,
            (sp_q.size() != 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0),
            fen, int'($urandom_range(0, PHY_REGS-1)), $urandom_range(0, 24) == 0);
    end
    cycle("final", 1'b0, 1'b0, 1'b0, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
